// File: rtl/sysctl_pkg.sv
// Shared encodings for the reset/error controller: FSM states and fault codes.
package sysctl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_EXT  = 2'd1,
        ERR_WDOG = 2'd2
    } err_code_t;

    localparam int CYC_W = 32;
    localparam int WD_W  = 16;

endpackage

// File: rtl/wdog_cnt.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and flags the last one.
module wdog_cnt
    import sysctl_pkg::*;
#(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic expire
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wd_cnt <= '0;
        end else if (en) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A clear on the expiry cycle (progress pulse) cancels the expiry.
    assign expire = en && !clear && (wd_cnt == WD_LAST);

endmodule

// File: rtl/rst_err_ctrl.sv
// Core reset stretcher and error supervisor: HOLD -> RUN, then HALT or a sticky FAULT.
// Handshake note: there are no valid/ready pairs; progress and err_in are sampled every cycle.
module rst_err_ctrl
    import sysctl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 4,
    parameter int WDOG_CYCLES     = 1024,
    parameter int NUM_ERR         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_ERR-1:0] err_in,
    input  logic               progress,
    input  logic               halt_in,
    output logic               core_rst,
    output logic               err,
    output logic [NUM_ERR-1:0] err_src,
    output logic [1:0]         err_code,
    output logic               halted,
    output logic [CYC_W-1:0]   cyc_cnt,
    output logic [1:0]         dbg_state
);

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [7:0]       hold_cnt;
    logic             wd_expire;
    logic             wd_en;
    logic             wd_clear;
    logic             fault_ext;
    logic             fault_wd;

    assign wd_en    = (state == ST_RUN);
    assign wd_clear = progress || (state != ST_RUN);

    wdog_cnt #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .en    (wd_en),
        .clear (wd_clear),
        .expire(wd_expire)
    );

    always_comb begin
        next_state = state;
        fault_ext  = 1'b0;
        fault_wd   = 1'b0;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) next_state = ST_RUN;
            end
            ST_RUN: begin
                // Priority: external error, then watchdog, then halt.
                if (|err_in) begin
                    next_state = ST_FAULT;
                    fault_ext  = 1'b1;
                end else if (wd_expire) begin
                    next_state = ST_FAULT;
                    fault_wd   = 1'b1;
                end else if (halt_in) begin
                    next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                if (|err_in) begin
                    next_state = ST_FAULT;
                    fault_ext  = 1'b1;
                end
            end
            default: next_state = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            core_rst <= 1'b1;
            err      <= 1'b0;
            err_src  <= '0;
            err_code <= ERR_NONE;
            halted   <= 1'b0;
            cyc_cnt  <= '0;
        end else begin
            state    <= next_state;
            core_rst <= (next_state == ST_HOLD);
            halted   <= (next_state == ST_HALT);
            hold_cnt <= (next_state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
            if (state == ST_RUN && cyc_cnt != {CYC_W{1'b1}}) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            // Fault details are captured once, on entry, and then held until reset.
            if (fault_ext) begin
                err      <= 1'b1;
                err_code <= ERR_EXT;
                err_src  <= err_in;
            end else if (fault_wd) begin
                err      <= 1'b1;
                err_code <= ERR_WDOG;
                err_src  <= '0;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rst_err_ctrl.sv
// Directed bench for rst_err_ctrl with RST_HOLD_CYCLES=4, WDOG_CYCLES=8, NUM_ERR=4.
module tb_rst_err_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  err_in = '0;
    logic        progress = 1'b0;
    logic        halt_in = 1'b0;
    logic        core_rst;
    logic        err;
    logic [3:0]  err_src;
    logic [1:0]  err_code;
    logic        halted;
    logic [31:0] cyc_cnt;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    rst_err_ctrl #(
        .RST_HOLD_CYCLES(4),
        .WDOG_CYCLES    (8),
        .NUM_ERR        (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .err_in   (err_in),
        .progress (progress),
        .halt_in  (halt_in),
        .core_rst (core_rst),
        .err      (err),
        .err_src  (err_src),
        .err_code (err_code),
        .halted   (halted),
        .cyc_cnt  (cyc_cnt),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic check_reset_vals(input string tag);
        chk({tag, ".core_rst"}, 33'(core_rst), 33'd1);
        chk({tag, ".err"},      33'(err),      33'd0);
        chk({tag, ".err_src"},  33'(err_src),  33'd0);
        chk({tag, ".err_code"}, 33'(err_code), 33'd0);
        chk({tag, ".halted"},   33'(halted),   33'd0);
        chk({tag, ".cyc_cnt"},  33'(cyc_cnt),  33'd0);
        chk({tag, ".state"},    33'(dbg_state), 33'd0);
    endtask

    task automatic do_reset(input int n);
        err_in   = '0;
        halt_in  = 1'b0;
        progress = 1'b0;
        rst      = 1'b1;
        repeat (n) tick();
        check_reset_vals("reset");
        rst = 1'b0;
    endtask

    // Expects {core_rst, cyc_cnt}: 4 stretched cycles, then RUN counting from 0.
    task automatic check_stretch(input string tag);
        logic [32:0] e;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 32'd0});
        exp_q.push_back({1'b0, 32'd0});
        exp_q.push_back({1'b0, 32'd1});
        exp_q.push_back({1'b0, 32'd2});
        progress = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, {core_rst, cyc_cnt}, e);
            tick();
        end
        progress = 1'b0;
    endtask

    task automatic go_run(input logic prog);
        do_reset(2);
        progress = prog;
        repeat (4) tick();
        chk("go_run.state", 33'(dbg_state), 33'd1);
    endtask

    initial begin
        // reset stretch and initial counting
        do_reset(2);
        check_stretch("stretch");

        // external error latches and holds while inputs keep toggling
        go_run(1'b1);
        repeat (3) tick();
        err_in = 4'b0100;
        tick();
        err_in = 4'b0000;
        chk("ext.err",      33'(err),      33'd1);
        chk("ext.err_code", 33'(err_code), 33'd1);
        chk("ext.err_src",  33'(err_src),  33'b0100);
        chk("ext.cyc_cnt",  33'(cyc_cnt),  33'd4);
        for (int i = 0; i < 20; i++) begin
            err_in  = 4'($urandom_range(0, 15));
            halt_in = 1'($urandom_range(0, 1));
            tick();
            chk("ext.hold", {err, err_code, err_src, cyc_cnt[26:0]}, {1'b1, 2'd1, 4'b0100, 27'd4});
        end
        err_in = '0;
        halt_in = 1'b0;
        chk("ext.core_rst", 33'(core_rst), 33'd0);

        // watchdog expiry after the 8th idle RUN cycle
        go_run(1'b0);
        repeat (7) tick();
        chk("wd.before", 33'(err), 33'd0);
        tick();
        chk("wd.err",      33'(err),      33'd1);
        chk("wd.err_code", 33'(err_code), 33'd2);
        chk("wd.err_src",  33'(err_src),  33'd0);
        chk("wd.cyc_cnt",  33'(cyc_cnt),  33'd8);

        // progress every 7 cycles keeps the watchdog quiet
        go_run(1'b0);
        for (int i = 0; i < 100; i++) begin
            progress = (i % 7 == 0);
            tick();
        end
        progress = 1'b0;
        chk("wd_ok.err",     33'(err),     33'd0);
        chk("wd_ok.cyc_cnt", 33'(cyc_cnt), 33'd100);

        // err_in beats watchdog and halt on the same edge
        go_run(1'b0);
        repeat (7) tick();
        err_in  = 4'b0001;
        halt_in = 1'b1;
        tick();
        err_in  = '0;
        halt_in = 1'b0;
        chk("prio.err",      33'(err),      33'd1);
        chk("prio.err_code", 33'(err_code), 33'd1);
        chk("prio.err_src",  33'(err_src),  33'b0001);
        chk("prio.halted",   33'(halted),   33'd0);

        // progress on the expiry cycle cancels it; watchdog then beats halt
        go_run(1'b0);
        repeat (7) tick();
        progress = 1'b1;
        tick();
        progress = 1'b0;
        chk("cancel.err", 33'(err), 33'd0);
        repeat (7) tick();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("wd_halt.err_code", 33'(err_code), 33'd2);
        chk("wd_halt.halted",   33'(halted),   33'd0);

        // halt freezes cyc_cnt and disables the watchdog; error still faults
        go_run(1'b0);
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("halt.halted",  33'(halted),  33'd1);
        chk("halt.cyc_cnt", 33'(cyc_cnt), 33'd1);
        repeat (50) tick();
        chk("halt.idle", {err, halted, cyc_cnt[30:0]}, {1'b0, 1'b1, 31'd1});
        err_in = 4'b1000;
        tick();
        err_in = '0;
        chk("halt_err.err",      33'(err),      33'd1);
        chk("halt_err.halted",   33'(halted),   33'd0);
        chk("halt_err.err_code", 33'(err_code), 33'd1);
        chk("halt_err.err_src",  33'(err_src),  33'b1000);
        chk("halt_err.cyc_cnt",  33'(cyc_cnt),  33'd1);

        // reset from FAULT for a single cycle repeats the whole stretch
        rst = 1'b1;
        tick();
        check_reset_vals("fault_rst");
        rst = 1'b0;
        check_stretch("restretch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rst_err_ctrl.md
RST_ERR_CTRL -- requirements
Module: rst_err_ctrl

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 4: cycles core_rst stays asserted after rst deasserts; legal range 1..255.
REQ-002 Parameter WDOG_CYCLES, default 1024: cycles in RUN without a progress pulse before a watchdog fault; legal range 2..65535.
REQ-003 Parameter NUM_ERR, default 4: number of per-unit error request lines.
REQ-004 Port clk, input, 1: single system clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port err_in, input, NUM_ERR: per-unit error flags; bit i set means unit i faulted this cycle.
REQ-007 Port progress, input, 1: one-cycle pulse per retired instruction.
REQ-008 Port halt_in, input, 1: core has executed HALT.
REQ-009 Port core_rst, output, 1: registered, stretched synchronous reset to the core.
REQ-010 Port err, output, 1: registered sticky error flag that drives the testbench clock/reset generator's err input.
REQ-011 Port err_src, output, NUM_ERR: err_in vector latched at fault time.
REQ-012 Port err_code, output, 2: 0 none, 1 external, 2 watchdog.
REQ-013 Port halted, output, 1: registered; set when the core is halted.
REQ-014 Port cyc_cnt, output, 32: count of RUN cycles.

Function
REQ-015 The FSM has four states: HOLD, RUN, HALT and FAULT.
REQ-016 HOLD: core_rst=1 and hold_cnt increments each cycle; at hold_cnt==RST_HOLD_CYCLES-1 the next state is RUN, so core_rst is high for exactly RST_HOLD_CYCLES cycles after the first cycle with rst low.
REQ-017 HOLD: err_in, progress and halt_in are ignored.
REQ-018 RUN: core_rst=0, and cyc_cnt increments by 1 per cycle, saturating at 0xFFFFFFFF with no wrap.
REQ-019 RUN watchdog: wd_cnt clears on any cycle with progress=1, otherwise increments; when wd_cnt==WDOG_CYCLES-1 with progress=0, next state is FAULT with err_code=2.
REQ-020 RUN: if any bit of err_in is set, next state is FAULT, err_code=1 and err_src=err_in as sampled at that edge.
REQ-021 RUN: halt_in=1 gives next state HALT and halted=1.
REQ-022 RUN priority for simultaneous events: err_in first, then watchdog, then halt_in; progress on the same cycle as watchdog expiry cancels the expiry.
REQ-023 HALT: cyc_cnt is frozen, the watchdog is disabled and cleared, and halted stays 1; any err_in bit moves to FAULT with err_code=1 and halted returning to 0.
REQ-024 FAULT: err=1, and err_src, err_code and cyc_cnt are held until rst; all inputs are ignored and core_rst stays 0.
REQ-025 Latency: an event sampled at edge k is visible on err, err_code, err_src and halted after edge k (one registered stage).
REQ-026 err_src is written only on the RUN/HALT to FAULT transition; a watchdog fault writes err_src=0.

Reset
REQ-027 While rst=1 at an edge, the block goes to state HOLD with hold_cnt=0, wd_cnt=0, core_rst=1, err=0, err_src=0, err_code=0, halted=0 and cyc_cnt=0.
REQ-028 rst asserted in any state, including mid-HOLD or FAULT, restarts the full HOLD sequence; there is no asynchronous path.

Structure
REQ-029 The state encodings (HOLD=0, RUN=1, HALT=2, FAULT=3) and err_code constants (NONE=0, EXT=1, WDOG=2) live in the shared package sysctl_pkg.
REQ-030 The watchdog is a separate sub-module, wdog_cnt, with inputs clk, rst, en, clear and output expire.
REQ-031 All outputs are driven directly from flops.

Verification (RST_HOLD_CYCLES=4, WDOG_CYCLES=8, NUM_ERR=4)
REQ-032 Reset stretch: rst high 2 cycles then low -> core_rst=1 for exactly 4 cycles after rst falls, then 0; cyc_cnt starts at 0 and then increments by 1 per cycle.
REQ-033 External error: in RUN, err_in=4'b0100 for 1 cycle -> next cycle err=1, err_code=1, err_src=4'b0100; cyc_cnt frozen; err stays 1 for 20 further cycles.
REQ-034 Watchdog: in RUN, progress held 0 -> err=1, err_code=2, err_src=0 after the 8th idle cycle; progress pulsed every 7 cycles -> no fault over 100 cycles.
REQ-035 Priority: err_in=4'b0001, halt_in=1 and watchdog expiry on the same edge -> err_code=1, halted=0.
REQ-036 Halt then error: halt_in=1 -> halted=1, cyc_cnt frozen, no watchdog fault over 50 idle cycles; then err_in=4'b1000 -> err=1, halted=0.
REQ-037 Reset mid-fault: in FAULT, rst high 1 cycle -> all outputs return to reset values and the 4-cycle core_rst stretch repeats.
